// File: rtl/hex_cal_pkg.sv
// Shared types and constants for the hex calculator parser: FSM states, operators,
// ASCII codes and the nibble-to-hex-character helper.
package hex_cal_pkg;

   typedef enum logic [2:0] {ST_OPA, ST_OPB, ST_CALC, ST_SEND, ST_ERR} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

   localparam logic [7:0] A_CR    = 8'h0D;
   localparam logic [7:0] A_LF    = 8'h0A;
   localparam logic [7:0] A_ESC   = 8'h1B;
   localparam logic [7:0] A_EQ    = 8'h3D;
   localparam logic [7:0] A_QM    = 8'h3F;
   localparam logic [7:0] A_PLUS  = 8'h2B;
   localparam logic [7:0] A_MINUS = 8'h2D;
   localparam logic [7:0] A_STAR  = 8'h2A;

   // 0-9 -> '0'-'9', 10-15 -> 'A'-'F' ('A' = 8'h37 + 10)
   function automatic logic [7:0] nib2ascii(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/hex_cal_ascii_dec.sv
// Combinational classifier for one received byte: hex digit value, operator, terminator, clear.
// Zero latency; no flow control.
module hex_cal_ascii_dec
   import hex_cal_pkg::*;
(
   input  logic [7:0] data,
   output logic       is_digit,
   output logic       is_op,
   output logic       is_term,
   output logic       is_esc,
   output logic [3:0] nib,
   output op_t        op
);

   always_comb begin
      is_digit = 1'b0;
      is_op    = 1'b0;
      nib      = data[3:0];
      op       = OP_ADD;
      if (data >= 8'h30 && data <= 8'h39) begin
         is_digit = 1'b1;
      end else if ((data >= 8'h41 && data <= 8'h46) || (data >= 8'h61 && data <= 8'h66)) begin
         is_digit = 1'b1;
         nib      = data[3:0] + 4'd9;
      end
      case (data)
         A_PLUS:  begin is_op = 1'b1; op = OP_ADD; end
         A_MINUS: begin is_op = 1'b1; op = OP_SUB; end
         A_STAR:  begin is_op = 1'b1; op = OP_MUL; end
         default: ;
      endcase
   end

   assign is_term = (data == A_EQ) || (data == A_CR);
   assign is_esc  = (data == A_ESC);

endmodule

// File: rtl/hex_cal_parser.sv
// Parses "<hexA><op><hexB>=" from rx bytes, replies with 2*DIGITS hex chars + CR LF (or "?" CR LF).
// One calc cycle, then at most one tx byte per 2 cycles; rx bytes arriving while replying are dropped
// with an overrun pulse. HEX_CAL_ECHO_EN adds a one-entry echo of parsed bytes ahead of replies.
module hex_cal_parser
   import hex_cal_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       overrun
);

   localparam int W   = 4 * DIGITS;
   localparam int R   = 8 * DIGITS;
   localparam int CW  = $clog2(DIGITS + 1);
   localparam int NCH = 2 * DIGITS + 2;
   localparam int IW  = $clog2(NCH);

   localparam logic [CW-1:0] MAX_CNT  = CW'(DIGITS);
   localparam logic [IW-1:0] CR_IDX   = IW'(2 * DIGITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(2 * DIGITS + 1);
   localparam logic [IW-1:0] ERR_LAST = IW'(2);

   state_t          state, state_nxt;
   logic [W-1:0]    opa, opb;
   logic [CW-1:0]   cnt_a, cnt_b;
   op_t             op_r;
   logic [R-1:0]    result, calc, res_sh;
   logic [IW-1:0]   idx;
   logic [7:0]      cur_char;
   logic            tx_is_echo;

   logic            is_digit, is_op, is_term, is_esc;
   logic [3:0]      nib;
   op_t             dec_op;

   logic            load_a, load_b, store_op, clr_ops, drop;
   logic            tx_fire, load_echo, load_char, echo_ovr;
   logic [7:0]      echo_buf;

   hex_cal_ascii_dec u_dec (
      .data     (rx_data),
      .is_digit (is_digit),
      .is_op    (is_op),
      .is_term  (is_term),
      .is_esc   (is_esc),
      .nib      (nib),
      .op       (dec_op)
   );

   assign tx_fire = tx_valid && tx_ready;
   assign busy    = (state == ST_CALC) || (state == ST_SEND);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= ST_OPA;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_a    = 1'b0;
      load_b    = 1'b0;
      store_op  = 1'b0;
      clr_ops   = 1'b0;
      drop      = 1'b0;
      unique case (state)
         ST_OPA: if (rx_valid) begin
            if (is_esc) begin
               clr_ops = 1'b1;
            end else if (is_digit && cnt_a != MAX_CNT) begin
               load_a = 1'b1;
            end else if (is_op && cnt_a != '0) begin
               store_op  = 1'b1;
               state_nxt = ST_OPB;
            end else if (!(rx_data == A_LF && cnt_a == '0)) begin
               state_nxt = ST_ERR;
            end
         end
         ST_OPB: if (rx_valid) begin
            if (is_esc) begin
               clr_ops   = 1'b1;
               state_nxt = ST_OPA;
            end else if (is_digit && cnt_b != MAX_CNT) begin
               load_b = 1'b1;
            end else if (is_term && cnt_b != '0) begin
               state_nxt = ST_CALC;
            end else begin
               state_nxt = ST_ERR;
            end
         end
         ST_CALC: begin
            drop      = rx_valid;
            state_nxt = ST_SEND;
         end
         ST_SEND: begin
            drop = rx_valid;
            if (tx_fire && !tx_is_echo && idx == LAST_IDX) begin
               state_nxt = ST_OPA;
               clr_ops   = 1'b1;
            end
         end
         ST_ERR: begin
            drop = rx_valid;
            if (tx_fire && !tx_is_echo && idx == ERR_LAST) begin
               state_nxt = ST_OPA;
               clr_ops   = 1'b1;
            end
         end
         default: state_nxt = ST_OPA;
      endcase
   end

   always_comb begin
      calc = '0;
      case (op_r)
         OP_ADD:  calc = {{W{1'b0}}, opa} + {{W{1'b0}}, opb};
         OP_SUB:  calc = {{W{1'b0}}, opa} - {{W{1'b0}}, opb};
         OP_MUL:  calc = {{W{1'b0}}, opa} * {{W{1'b0}}, opb};
         default: calc = '0;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         opa    <= '0;
         opb    <= '0;
         cnt_a  <= '0;
         cnt_b  <= '0;
         op_r   <= OP_ADD;
         result <= '0;
         idx    <= '0;
      end else begin
         if (clr_ops) begin
            opa   <= '0;
            opb   <= '0;
            cnt_a <= '0;
            cnt_b <= '0;
         end else begin
            if (load_a) begin
               opa   <= W'({opa, nib});
               cnt_a <= cnt_a + CW'(1);
            end
            if (load_b) begin
               opb   <= W'({opb, nib});
               cnt_b <= cnt_b + CW'(1);
            end
         end
         if (store_op)           op_r   <= dec_op;
         if (state == ST_CALC)   result <= calc;
         if (tx_fire && !tx_is_echo) idx <= (state_nxt == ST_OPA) ? '0 : idx + IW'(1);
      end
   end

   // Shift the wanted nibble to the top so the index needs no variable part-select
   always_comb begin
      res_sh   = result << {idx, 2'b00};
      cur_char = A_LF;
      if (state == ST_ERR) begin
         if (idx == '0)           cur_char = A_QM;
         else if (idx == IW'(1))  cur_char = A_CR;
      end else if (idx < CR_IDX) begin
         cur_char = nib2ascii(res_sh[R-1 -: 4]);
      end else if (idx == CR_IDX) begin
         cur_char = A_CR;
      end
   end

`ifdef HEX_CAL_ECHO_EN
   logic echo_full;
   logic echo_in;

   assign echo_in   = rx_valid && (state == ST_OPA || state == ST_OPB);
   assign load_echo = echo_full && !tx_valid;
   assign echo_ovr  = echo_in && echo_full && !load_echo;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         echo_full <= 1'b0;
         echo_buf  <= 8'h00;
      end else if (echo_in && (!echo_full || load_echo)) begin
         echo_full <= 1'b1;
         echo_buf  <= rx_data;
      end else if (load_echo) begin
         echo_full <= 1'b0;
      end
   end
`else
   assign load_echo = 1'b0;
   assign echo_ovr  = 1'b0;
   assign echo_buf  = 8'h00;
`endif

   // Pending echo always wins the tx register, so echoed input precedes any reply
   assign load_char = !tx_valid && !load_echo && (state == ST_SEND || state == ST_ERR);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         tx_data    <= 8'h00;
         tx_valid   <= 1'b0;
         tx_is_echo <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= drop || echo_ovr;
         if (tx_fire) begin
            tx_valid <= 1'b0;
         end else if (load_echo) begin
            tx_data    <= echo_buf;
            tx_valid   <= 1'b1;
            tx_is_echo <= 1'b1;
         end else if (load_char) begin
            tx_data    <= cur_char;
            tx_valid   <= 1'b1;
            tx_is_echo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hex_cal_parser.sv
// Directed bench for hex_cal_parser: sends calculator expressions and checks the tx byte stream.
module tb_hex_cal_parser;

`ifdef HEX_CAL_ECHO_EN
   localparam bit ECHO = 1'b1;
`else
   localparam bit ECHO = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic       busy;
   logic       overrun;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         ovr_cnt = 0;
   int         ovr_base = 0;
   logic [7:0] txq[$];

   localparam string CRLF = "\015\012";

   always #5 clk = ~clk;

   hex_cal_parser #(.DIGITS(4)) dut (
      .clk      (clk),
      .n_rst    (n_rst),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .overrun  (overrun)
   );

   // Inputs change just after posedge, so at negedge they are settled for the next edge
   always @(negedge clk) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (overrun) ovr_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic start_case();
      txq.delete();
      ovr_base = ovr_cnt;
   endtask

   task automatic wait_size(input string tag, input int n);
      int budget = 0;
      while (txq.size() < n && budget < 600) begin
         @(negedge clk);
         budget++;
      end
      chk({tag, "_wait"}, 32'(txq.size() >= n), 32'd1);
   endtask

   task automatic check_reply(input string tag, input string exp, input int exp_ovr);
      wait_size(tag, exp.len());
      repeat (6) @(negedge clk);
      chk({tag, "_len"}, 32'(txq.size()), 32'(exp.len()));
      for (int i = 0; i < exp.len(); i++)
         chk($sformatf("%s[%0d]", tag, i), 32'((i < txq.size()) ? txq[i] : 8'h00), 32'(exp[i]));
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
      chk({tag, "_ovr"}, 32'(ovr_cnt - ovr_base), 32'(exp_ovr));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      string e;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_txv", 32'(tx_valid), 32'd0);
      chk("rst_txd", 32'(tx_data), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      @(negedge clk);
      n_rst = 1'b1;

      // 1: basic add, busy during reply
      start_case();
      send_str("12+34=");
      chk("t1_busy", 32'(busy), 32'd1);
      check_reply("t1", {ECHO ? "12+34=" : "", "00000046", CRLF}, 0);

      // 2: max multiply, lowercase digits, CR terminator
      start_case();
      e = "FFFF*ffff\015";
      send_str(e);
      check_reply("t2", {ECHO ? e : "", "FFFE0001", CRLF}, 0);

      // 3: subtraction wraps, then a fresh expression
      start_case();
      send_str("1-2=");
      check_reply("t3a", {ECHO ? "1-2=" : "", "FFFFFFFF", CRLF}, 0);
      start_case();
      send_str("5+5=");
      check_reply("t3b", {ECHO ? "5+5=" : "", "0000000A", CRLF}, 0);

      // 4: error recovery
      start_case();
      send_str("12G");
      check_reply("t4a", {ECHO ? "12G" : "", "?", CRLF}, 0);
      start_case();
      send_str("12345+");
      check_reply("t4b", {ECHO ? "12345" : "", "?", CRLF}, 1);
      start_case();
      send_str("+");
      check_reply("t4c", {ECHO ? "+" : "", "?", CRLF}, 0);
      start_case();
      send_str("12");
      send_byte(8'h1B);
      send_str("3+4=");
      check_reply("t4d", {ECHO ? {"12", "\033", "3+4="} : "", "00000007", CRLF}, 0);

      // 5: backpressure on the 3rd result char, plus a byte dropped mid-reply
      start_case();
      send_str("A+1=");
      wait_size("t5_pre", (ECHO ? 4 : 0) + 2);
      @(posedge clk); #1;
      tx_ready = 1'b0;
      repeat (50) @(negedge clk);
      chk("t5_hold_v", 32'(tx_valid), 32'd1);
      chk("t5_hold_d", 32'(tx_data), 32'h30);
      send_byte(8'h39);
      repeat (50) @(negedge clk);
      chk("t5_hold_v2", 32'(tx_valid), 32'd1);
      chk("t5_hold_d2", 32'(tx_data), 32'h30);
      chk("t5_hold_n", 32'(txq.size()), 32'((ECHO ? 4 : 0) + 2));
      @(posedge clk); #1;
      tx_ready = 1'b1;
      check_reply("t5", {ECHO ? "A+1=" : "", "0000000B", CRLF}, 1);

      // 6: async reset during reply, then normal operation
      start_case();
      send_str("1+2=");
      wait_size("t6_pre", (ECHO ? 4 : 0) + 3);
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      chk("t6_rst_txv", 32'(tx_valid), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      start_case();
      send_str("1+1=");
      check_reply("t6", {ECHO ? "1+1=" : "", "00000002", CRLF}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hex_cal_parser.md
Name: hex_cal_parser

Overview:
Downstream stage of the UART receiver in the hex-calculator lab. Consumes received ASCII bytes, parses `<hexA><op><hexB>=`, and computes the result. Emits the result as uppercase ASCII hex plus CR LF over a valid/ready byte interface to the UART transmitter. Malformed input produces a short error reply and restarts parsing.

Parameters:
DIGITS, 4, max hex digits per operand; operand width W = 4*DIGITS, result width R = 8*DIGITS.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
rx_data  input  8  received byte; valid only while rx_valid=1
rx_valid  input  1  one-cycle pulse per received byte
tx_data  output  8  ASCII byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte this cycle
busy  output  1  high in CALC/SEND
overrun  output  1  one-cycle pulse when a byte is dropped

Behaviour:
- Reset: state=OPA, operands/result/counters=0, tx_data=8'h00, tx_valid=0, busy=0, overrun=0. Async reset mid-SEND aborts output immediately.
- Digit decode: '0'-'9', 'A'-'F', 'a'-'f' map to a nibble; any other byte is "other".
- Operators: '+' (8'h2B), '-' (8'h2D), '*' (8'h2A). Terminators: '=' (8'h3D), CR (8'h0D). ESC (8'h1B) = clear.
- OPA:
  - digit: opa <= {opa[W-5:0],nib}, cntA++.
  - operator with 1<=cntA: store op, go to OPB.
  - (DIGITS+1)th digit, operator with cntA=0, or other byte -> ERR.
- OPB:
  - digits same rules into opb.
  - terminator with cntB>=1 -> CALC.
  - operator, excess digit, or other byte -> ERR.
- ESC in OPA/OPB: clear operands and counters, return to OPA, no output. LF (8'h0A) in OPA with cntA=0 is ignored.
- CALC (1 cycle): operands zero-extended to R.
  - '+': result = a+b.
  - '-': result = (a-b) mod 2^R.
  - '*': result = a*b.
  - Then go to SEND with char index 0.
- SEND: emits 2*DIGITS nibbles MSB-first as '0'-'9'/'A'-'F', then CR, LF.
- ERR: emits '?', CR, LF, then returns to OPA with operands cleared.
- TX handshake:
  - tx_valid is registered; tx_data is stable while tx_valid=1.
  - A byte transfers on a cycle with tx_valid&&tx_ready; the next byte is presented the following cycle, or the same-cycle pipeline may hold.
  - Minimum one byte per 2 cycles.
- After the final LF transfers: tx_valid=0, busy=0, state=OPA, operands cleared.
- rx_valid while in CALC/SEND/ERR-send: byte dropped, overrun=1 for one cycle, no state change.
- rx_valid and last-LF transfer in the same cycle: byte dropped with overrun (state is still SEND that cycle).

Optional Feature:
HEX_CAL_ECHO_EN:
- Defined: every byte accepted in OPA/OPB is copied into a one-entry echo buffer and sent on tx before any other output.
  - Entry to SEND/ERR-send waits until the echo buffer drains, so the echoed '=' precedes the result.
  - New byte with the buffer still full: byte is still parsed, echo dropped, overrun pulses.
- Undefined: no echo buffer; tx carries only results and error replies.

Decomposition:
- Package hex_cal_pkg:
  - state encoding (OPA, OPB, CALC, SEND, ERR);
  - op encoding (ADD, SUB, MUL);
  - ASCII constants (CR, LF, ESC, '=', '?', '+', '-', '*');
  - nibble-to-ASCII function.
- Sub-module hex_cal_ascii_dec: combinational byte -> {is_digit, is_op, is_term, is_esc, nib[3:0], op}. The parser instantiates it once.

Test Plan:
1. rx "12+34=" (DIGITS=4), tx_ready=1 -> tx "00000046" CR LF, busy high throughout, overrun never.
2. rx "FFFF*ffff" CR -> tx "FFFE0001" CR LF.
3. rx "1-2=" -> tx "FFFFFFFF" CR LF. Then rx "5+5=" -> "0000000A" CR LF.
4. Error recovery:
   - rx "12G" -> tx '?' CR LF, back in OPA.
   - rx "12345+" -> '?' CR LF.
   - rx "+" -> '?' CR LF.
   - rx "12" ESC "3+4=" -> "00000007" CR LF.
5. rx "A+1=", tx_ready low 100 cycles at the 3rd char -> tx_data held at '0' with tx_valid=1, no char lost or duplicated. Byte sent during SEND -> single overrun pulse, result unchanged.
6. Assert n_rst low during SEND -> tx_valid=0, busy=0 immediately. After release, rx "1+1=" -> "00000002" CR LF. With HEX_CAL_ECHO_EN: echo "1+1=" precedes the result.
